// File: rtl/rcon_seq_if.sv
// Request/response bundle between the round-constant generator and its consumer.
interface rcon_seq_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic              start;
    logic [1:0]        mode;
    logic              next;
    logic [WORD_W-1:0] rcon;
    logic              rcon_valid;
    logic [3:0]        index;
    logic              last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, mode, next,
        input  rcon, rcon_valid, index, last, busy, done, err
    );

    modport slave (
        input  start, mode, next,
        output rcon, rcon_valid, index, last, busy, done, err
    );
endinterface

// File: rtl/rcon_seq.sv
// AES round-constant sequencer: emits one Rcon word per consumer handshake,
// producing each constant by GF(2^8) doubling of the previous one.
module rcon_seq #(
    parameter int unsigned WORD_W = 32,
    parameter logic [7:0]  POLY   = 8'h1B
) (
    input  logic        clk,
    input  logic        rst_n,
    rcon_seq_if.slave   bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SHIFT  = WORD_W - BYTE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_byte;
    logic [IDX_W-1:0]    r_n;
    logic [IDX_W-1:0]    r_index;
    logic [WORD_W-1:0]   r_rcon;
    logic                r_valid;
    logic                r_last;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [BYTE_W-1:0]   w_xtime;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [IDX_W-1:0]    w_last_idx;
    logic [IDX_W-1:0]    w_mode_n;
    logic                w_consume;

    // Place the Rcon byte in the top byte of the word, zeros elsewhere.
    function automatic logic [WORD_W-1:0] place_byte(input logic [BYTE_W-1:0] b);
        place_byte = WORD_W'(b) << SHIFT;
    endfunction

    always_comb begin
        w_xtime    = {r_byte[BYTE_W-2:0], 1'b0} ^ (r_byte[BYTE_W-1] ? POLY : 8'h00);
        w_idx_inc  = r_index + IDX_W'(1);
        w_last_idx = r_n - IDX_W'(1);
        w_consume  = r_valid && bus.next;
        unique case (bus.mode)
            2'b01:   w_mode_n = IDX_W'(8);
            2'b10:   w_mode_n = IDX_W'(7);
            default: w_mode_n = IDX_W'(10);
        endcase
    end

    // Sequencer FSM; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_byte  <= 8'h01;
            r_n     <= IDX_W'(10);
            r_index <= '0;
            r_rcon  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.mode == 2'b11) begin
                            r_err <= 1'b1;
                        end else begin
                            r_n     <= w_mode_n;
                            r_state <= ST_RUN;
                            r_byte  <= 8'h01;
                            r_index <= '0;
                            r_rcon  <= place_byte(8'h01);
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_last  <= (w_mode_n == IDX_W'(1));
                        end
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here; mode is only read in IDLE.
                    if (w_consume) begin
                        if (r_index == w_last_idx) begin
                            r_state <= ST_IDLE;
                            r_byte  <= 8'h01;
                            r_index <= '0;
                            r_rcon  <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_byte  <= w_xtime;
                            r_index <= w_idx_inc;
                            r_rcon  <= place_byte(w_xtime);
                            r_last  <= (w_idx_inc == w_last_idx);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rcon       = r_rcon;
    assign bus.rcon_valid = r_valid;
    assign bus.index      = r_index;
    assign bus.last       = r_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_rcon_seq.sv
// Scoreboard bench for rcon_seq: a 32-bit/0x1B instance and an 8-bit/0x1D
// instance share the same stimulus and are checked against hand-written tables.
module tb_rcon_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       next;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rcon;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic [7:0] s1b [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [7:0] s1d [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

    rcon_seq_if #(.WORD_W(32)) ifa ();
    rcon_seq_if #(.WORD_W(8))  ifb ();

    assign ifa.start = start;
    assign ifa.mode  = mode;
    assign ifa.next  = next;
    assign ifb.start = start;
    assign ifb.mode  = mode;
    assign ifb.next  = next;

    rcon_seq #(.WORD_W(32), .POLY(8'h1B)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rcon_seq #(.WORD_W(8),  .POLY(8'h1D)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_words(input int n, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.rcon = {s1b[i], 24'h0};
            e.idx  = 4'(i);
            e.last = (i == n - 1);
            qa.push_back(e);
            e.rcon = {24'h0, s1d[i]};
            qb.push_back(e);
        end
    endtask

    // Monitors: pop one expected word per consumed word.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ifa.rcon_valid && ifa.next) begin
                if (qa.size() == 0) chk("a_unexpected_word", ifa.rcon, 32'hFFFF_FFFF);
                else begin
                    e = qa.pop_front();
                    chk("a_rcon", ifa.rcon, e.rcon);
                    chk("a_index", 32'(ifa.index), 32'(e.idx));
                    chk("a_last", 32'(ifa.last), 32'(e.last));
                end
            end else if (!ifa.rcon_valid) begin
                chk("a_rcon_zero_idle", ifa.rcon, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ifb.rcon_valid && ifb.next) begin
                if (qb.size() == 0) chk("b_unexpected_word", 32'(ifb.rcon), 32'hFFFF_FFFF);
                else begin
                    e = qb.pop_front();
                    chk("b_rcon", 32'(ifb.rcon), e.rcon);
                    chk("b_index", 32'(ifb.index), 32'(e.idx));
                    chk("b_last", 32'(ifb.last), 32'(e.last));
                end
            end
        end
    end

    // Issue start now (caller aligns to posedge+1) and drive next until done.
    // stall: 0 = next held high, 1 = next pattern 1,0,0 repeating.
    task automatic run_seq(input logic [1:0] m, input int n, input bit stall, input bit start_in_run);
        int cnt;
        push_words(n, n);
        start = 1'b1;
        mode  = m;
        next  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_valid", 32'(ifa.rcon_valid), 32'h1);
        chk("first_index", 32'(ifa.index), 32'h0);
        chk("first_busy", 32'(ifa.busy), 32'h1);
        chk("done_one_cycle", 32'(ifa.done), 32'h0);
        cnt  = 0;
        next = 1'b1;
        while (!ifa.done && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
            next = stall ? (cnt % 3 == 0) : 1'b1;
            if (start_in_run) begin
                start = (cnt == 3);
                if (cnt == 3) mode = 2'b00;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(ifa.done), 32'h1);
        chk("b_done_seen", 32'(ifb.done), 32'h1);
        chk("done_busy", 32'(ifa.busy), 32'h0);
        chk("done_valid", 32'(ifa.rcon_valid), 32'h0);
        chk("done_last", 32'(ifa.last), 32'h0);
        chk("a_queue_drained", 32'(qa.size()), 32'h0);
        chk("b_queue_drained", 32'(qb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        next  = 1'b0;
        #1;
        chk("rst_rcon", ifa.rcon, 32'h0);
        chk("rst_valid", 32'(ifa.rcon_valid), 32'h0);
        chk("rst_index", 32'(ifa.index), 32'h0);
        chk("rst_busy", 32'(ifa.busy), 32'h0);
        chk("rst_done", 32'(ifa.done), 32'h0);
        chk("rst_err", 32'(ifa.err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // AES-128, next held high
        @(posedge clk); #1;
        run_seq(2'b00, 10, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_cleared", 32'(ifa.done), 32'h0);

        // AES-192 with stalls
        run_seq(2'b01, 8, 1'b1, 1'b0);

        // AES-256 with a start during RUN, then a restart in the done cycle
        @(posedge clk); #1;
        run_seq(2'b10, 7, 1'b0, 1'b1);
        run_seq(2'b00, 10, 1'b0, 1'b0);

        // reserved mode
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'b11;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", 32'(ifa.err), 32'h1);
        chk("b_err_pulse", 32'(ifb.err), 32'h1);
        chk("err_busy", 32'(ifa.busy), 32'h0);
        chk("err_valid", 32'(ifa.rcon_valid), 32'h0);
        @(posedge clk); #1;
        chk("err_one_cycle", 32'(ifa.err), 32'h0);
        run_seq(2'b00, 10, 1'b0, 1'b0);

        // async reset at index 5
        @(posedge clk); #1;
        push_words(10, 5);
        start = 1'b1;
        mode  = 2'b00;
        next  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt   = 0;
        while (ifa.index != 4'd5 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        next = 1'b0;
        chk("pre_reset_index", 32'(ifa.index), 32'h5);
        chk("pre_reset_rcon", ifa.rcon, 32'h2000_0000);
        chk("b_pre_reset_rcon", 32'(ifb.rcon), 32'h20);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rcon", ifa.rcon, 32'h0);
        chk("async_valid", 32'(ifa.rcon_valid), 32'h0);
        chk("async_index", 32'(ifa.index), 32'h0);
        chk("async_busy", 32'(ifa.busy), 32'h0);
        chk("b_async_rcon", 32'(ifb.rcon), 32'h0);
        chk("a_queue_at_reset", 32'(qa.size()), 32'h0);
        chk("b_queue_at_reset", 32'(qb.size()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_rcon", ifa.rcon, 32'h0);
        run_seq(2'b00, 10, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rcon_seq.md
Name: rcon_seq

Overview:
- Sequential AES round-constant generator, feeding the key-expansion datapath one Rcon word per consumer request.
- Computes each constant on the fly by GF(2^8) doubling (xtime) instead of using a lookup table.
- Supports AES-128/192/256 sequence lengths.
- Parametrised in word width and reduction polynomial.

Parameters:
- WORD_W, 32, output word width; must be >= 8. The Rcon byte occupies bits [WORD_W-1:WORD_W-8]; all other bits are 0.
- POLY, 8'h1B, reduction polynomial low byte used by xtime.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new sequence; sampled only in IDLE.
- mode  in  2  key size, sampled with start: 00 = AES-128 (N=10), 01 = AES-192 (N=8), 10 = AES-256 (N=7), 11 = reserved.
- next  in  1  consumer ready; the current word is consumed when rcon_valid && next.
- rcon  out  WORD_W  current round-constant word; 0 when rcon_valid = 0.
- rcon_valid  out  1  rcon/index hold a valid entry.
- index  out  4  0-based position of the current word in the sequence.
- last  out  1  current word is the final one (index == N-1), qualified by rcon_valid.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse after the final word is consumed.
- err  out  1  one-cycle pulse when start is accepted with mode = 11.

Behaviour:
- All outputs are registered.
- Reset (async assert, any state, including mid-sequence):
  - FSM returns to IDLE.
  - rcon = 0, rcon_valid = 0, index = 0, last = 0, busy = 0, done = 0, err = 0.
  - Internal byte register = 8'h01; latched N = 10.
- FSM states: IDLE, RUN.
- IDLE:
  - start = 1 with mode != 11: latch N. In the next cycle RUN is entered with byte = 01, index = 0, rcon_valid = 1, busy = 1, last = (N == 1, never true for legal modes). Latency from start to first valid word is 1 cycle.
  - start = 1 with mode = 11: stay in IDLE; err = 1 for exactly one cycle; nothing else changes.
  - start = 0: outputs hold their idle values.
- RUN, rcon_valid && next && index != N-1:
  - byte <= xtime(byte) = {byte[6:0],1'b0} ^ (byte[7] ? POLY : 8'h00).
  - index <= index + 1; last <= (index + 1 == N-1).
  - rcon_valid stays 1, so back-to-back consumption gives one word per cycle.
- RUN, rcon_valid && next && index == N-1:
  - Next cycle: IDLE, rcon_valid = 0, rcon = 0, last = 0, busy = 0, done = 1 for one cycle.
  - byte resets to 01; index resets to 0.
- RUN, next = 0 (stall): rcon, index and last hold indefinitely.
- start while in RUN, including the cycle of the final consume: ignored. No err, no restart, mode not re-sampled.
- start in the cycle done is high: FSM is already IDLE, so start is accepted normally. Back-to-back sequences have exactly one idle cycle between them.
- mode changes during RUN have no effect; N is latched only at start.
- With POLY = 1B the byte sequence is 01,02,04,08,10,20,40,80,1B,36. The sequence ends at 36 for AES-128, 80 for AES-192 and 40 for AES-256.
- Overflow is impossible: index never exceeds N-1 <= 9, and the 4-bit index has headroom for N up to 15.

Test Plan:
1. Reset, then mode = 00 with start pulsed for 1 cycle and next held at 1:
   - 1 cycle later rcon = 32'h01000000, index = 0.
   - Following cycles give 02,04,08,10,20,40,80,1B,36 (×2^24).
   - last = 1 only with 36 (index = 9); done pulses on the cycle after 36; busy drops in the same cycle.
2. mode = 01, next toggled 1,0,0,1,…:
   - Each word holds during stalls.
   - Exactly 8 words, ending at 32'h80000000 with last = 1.
   - done pulses once after that word is consumed.
3. mode = 10, next = 1:
   - 7 words, 01 through 40.
   - Assert start during RUN: no restart, index continues uninterrupted.
   - Then assert start in the done cycle: new sequence begins at 01.
4. mode = 11 with start:
   - err = 1 for one cycle; busy = 0; rcon_valid = 0.
   - A following start with mode = 00 works normally.
5. Deassert rst_n asynchronously at index = 5 (rcon = 32'h20000000):
   - Outputs go to zero immediately, without waiting for clk.
   - After release, start with mode = 00 restarts at 01, index = 0.
6. WORD_W = 8, POLY = 8'h1D, mode = 00:
   - rcon sequence is 01,02,04,08,10,20,40,80,1D,3A.
